// File: rtl/hdmi_axi_packer_if.sv
// Pixel-in / word-out stream bundle for hdmi_axi_packer.
// master: the packer side; slave: the pixel source / word sink side.
// Optional HDMI_PACK_STATS_EN adds drop_cnt and frame_len_err.
interface hdmi_axi_packer_if;
  logic        frame_start;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_last;
  logic        pix_ready;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic        tx_ready;
  logic        synced;
`ifdef HDMI_PACK_STATS_EN
  logic [15:0] drop_cnt;
  logic        frame_len_err;

  modport master (
    input  frame_start, pix_valid, pix_data, pix_last, tx_ready,
    output pix_ready, tx_valid, tx_data, synced, drop_cnt, frame_len_err
  );
  modport slave (
    output frame_start, pix_valid, pix_data, pix_last, tx_ready,
    input  pix_ready, tx_valid, tx_data, synced, drop_cnt, frame_len_err
  );
`else
  modport master (
    input  frame_start, pix_valid, pix_data, pix_last, tx_ready,
    output pix_ready, tx_valid, tx_data, synced
  );
  modport slave (
    output frame_start, pix_valid, pix_data, pix_last, tx_ready,
    input  pix_ready, tx_valid, tx_data, synced
  );
`endif
endinterface

// File: rtl/hdmi_axi_packer.sv
// Packs 24-bit pixels two per 64-bit word, inserts a boundary word at each
// frame start and flushes a lone pixel at line end or frame start.
// Word: [63:16] payload, [15:14] kind (01 single, 10 dual, 11 boundary),
// [13:0] line index (pixel words) or frame counter (boundary words).
// Optional macro HDMI_PACK_STATS_EN adds drop_cnt and frame_len_err.
module hdmi_axi_packer #(
  parameter logic [47:0] BND_DATA = 48'hFEFEFEFEFEFE,
  parameter int unsigned LINE_W   = 12,
  parameter int unsigned FRAME_W  = 14
) (
  input  logic              axi_clk,
  input  logic              rst_n,
  hdmi_axi_packer_if.master bus
);

  typedef enum logic [2:0] {
    S_WAIT_FRAME,
    S_EMIT_BND,
    S_PAIR0,
    S_PAIR1,
    S_FLUSH
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_live;
  logic                r_bnd_pending, w_bnd_pending_nxt;
  logic                r_synced, w_synced_nxt;
  logic [LINE_W-1:0]   r_line, w_line_nxt;
  logic [FRAME_W-1:0]  r_frame, w_frame_nxt;
  logic [23:0]         r_held, w_held_nxt;
  logic                r_tx_valid;
  logic [63:0]         r_tx_data;
  logic                w_load, w_load_bnd;
  logic [63:0]         w_word;
  logic                w_out_free, w_accept, w_pix_ready;
  logic [13:0]         w_line_f, w_frame_f;

  assign w_out_free = !r_tx_valid || bus.tx_ready;
  assign w_line_f   = 14'(r_line);
  assign w_frame_f  = 14'(r_frame);

  // Pixel acceptance: drop freely while unsynced, otherwise only when the output register can take a word.
  always_comb begin
    w_pix_ready = 1'b0;
    case (r_state)
      S_WAIT_FRAME:     w_pix_ready = r_live;
      S_PAIR0, S_PAIR1: w_pix_ready = !r_bnd_pending && w_out_free;
      default:          w_pix_ready = 1'b0;
    endcase
  end

  assign w_accept = bus.pix_valid && w_pix_ready;

  // A frame_start coinciding with the boundary load starts a fresh pending request.
  assign w_bnd_pending_nxt = bus.frame_start || (r_bnd_pending && !w_load_bnd);

  // Next-state and word assembly.
  always_comb begin
    w_state_nxt  = r_state;
    w_line_nxt   = r_line;
    w_frame_nxt  = r_frame;
    w_held_nxt   = r_held;
    w_synced_nxt = r_synced;
    w_load       = 1'b0;
    w_load_bnd   = 1'b0;
    w_word       = '0;
    case (r_state)
      S_WAIT_FRAME: begin
        if (bus.frame_start) w_state_nxt = S_EMIT_BND;
      end
      S_EMIT_BND: begin
        if (w_out_free) begin
          w_load       = 1'b1;
          w_load_bnd   = 1'b1;
          w_word       = {BND_DATA, 2'b11, w_frame_f};
          w_frame_nxt  = r_frame + 1'b1;
          w_line_nxt   = '0;
          w_synced_nxt = 1'b1;
          w_state_nxt  = S_PAIR0;
        end
      end
      S_PAIR0: begin
        if (r_bnd_pending) begin
          w_state_nxt = S_EMIT_BND;
        end else if (w_accept) begin
          if (bus.pix_last) begin
            w_load     = 1'b1;
            w_word     = {24'h0, bus.pix_data, 2'b01, w_line_f};
            w_line_nxt = r_line + 1'b1;
          end else begin
            w_held_nxt  = bus.pix_data;
            w_state_nxt = S_PAIR1;
          end
        end
      end
      S_PAIR1: begin
        if (r_bnd_pending) begin
          w_state_nxt = S_FLUSH;
        end else if (w_accept) begin
          w_load      = 1'b1;
          w_word      = {bus.pix_data, r_held, 2'b10, w_line_f};
          w_state_nxt = S_PAIR0;
          if (bus.pix_last) w_line_nxt = r_line + 1'b1;
        end
      end
      S_FLUSH: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_word      = {24'h0, r_held, 2'b01, w_line_f};
          w_state_nxt = S_EMIT_BND;
        end
      end
      default: w_state_nxt = S_WAIT_FRAME;
    endcase
  end

  // Control state registers.
  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_WAIT_FRAME;
      r_live        <= 1'b0;
      r_bnd_pending <= 1'b0;
      r_synced      <= 1'b0;
      r_line        <= '0;
      r_frame       <= '0;
      r_held        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_live        <= 1'b1;
      r_bnd_pending <= w_bnd_pending_nxt;
      r_synced      <= w_synced_nxt;
      r_line        <= w_line_nxt;
      r_frame       <= w_frame_nxt;
      r_held        <= w_held_nxt;
    end
  end

  // Output word register: holds while stalled, reloads in the same cycle it is taken.
  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (w_load) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= w_word;
    end else if (bus.tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign bus.pix_ready = w_pix_ready;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.tx_data   = r_tx_data;
  assign bus.synced    = r_synced;

`ifdef HDMI_PACK_STATS_EN
  logic [15:0] r_drop_cnt;
  logic        r_frame_len_err;

  // Saturating count of pixels discarded before the first frame start.
  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (r_state == S_WAIT_FRAME && w_accept && r_drop_cnt != '1) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Line-count check on each boundary except the first one after reset.
  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_len_err <= 1'b0;
    end else begin
      r_frame_len_err <= w_load_bnd && r_synced && (r_line != LINE_W'(1080));
    end
  end

  assign bus.drop_cnt      = r_drop_cnt;
  assign bus.frame_len_err = r_frame_len_err;
`endif

endmodule

// File: tb/tb_hdmi_axi_packer.sv
// Self-checking bench for hdmi_axi_packer: randomized pixels checked against
// a queue-based reference model of the packing rules.
module tb_hdmi_axi_packer;

  localparam logic [47:0] BND = 48'hFEFEFEFEFEFE;

  logic axi_clk = 1'b0;
  logic rst_n   = 1'b0;

  hdmi_axi_packer_if bus ();

  hdmi_axi_packer #(
    .BND_DATA (BND),
    .LINE_W   (12),
    .FRAME_W  (14)
  ) dut (
    .axi_clk (axi_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 axi_clk = ~axi_clk;

  // Reference model state
  logic [63:0] exp_q[$];
  logic [63:0] ref_q[$];
  logic [63:0] obs_q[$];
  bit          m_in_frame;
  logic [13:0] m_frame;
  logic [11:0] m_line;
  bit          m_held_v;
  logic [23:0] m_held;

  // Observation (written only by the monitor)
  logic [63:0] got_q[$];
  int          stall_viol  = 0;
  int          len_err_cnt = 0;
  logic        prev_stall  = 1'b0;
  logic [63:0] prev_data   = '0;

  // Bench bookkeeping (written only by the main process)
  int got_rd  = 0;
  int pix_to  = 0;
  int n_pass  = 0;
  int n_total = 0;
  int rdy_mode = 0;

  task automatic model_reset();
    m_in_frame = 0; m_frame = '0; m_line = '0; m_held_v = 0; m_held = '0;
    exp_q.delete();
  endtask

  task automatic model_frame();
    if (m_held_v) exp_q.push_back({24'h0, m_held, 2'b01, 2'b00, m_line});
    m_held_v = 0;
    exp_q.push_back({BND, 2'b11, m_frame});
    m_frame    = m_frame + 14'd1;
    m_line     = '0;
    m_in_frame = 1;
  endtask

  task automatic model_pixel(input logic [23:0] d, input bit last);
    if (!m_in_frame) return;
    if (m_held_v) begin
      exp_q.push_back({d, m_held, 2'b10, 2'b00, m_line});
      m_held_v = 0;
      if (last) m_line = m_line + 12'd1;
    end else if (last) begin
      exp_q.push_back({24'h0, d, 2'b01, 2'b00, m_line});
      m_line = m_line + 12'd1;
    end else begin
      m_held   = d;
      m_held_v = 1;
    end
  endtask

  // Word monitor: records accepted words and checks stall stability.
  always @(negedge axi_clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data)) stall_viol++;
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) got_q.push_back(bus.tx_data);
`ifdef HDMI_PACK_STATS_EN
      if (bus.frame_len_err === 1'b1) len_err_cnt++;
`endif
      prev_stall = (bus.tx_valid === 1'b1) && (bus.tx_ready === 1'b0);
      prev_data  = bus.tx_data;
    end
  end

  // Downstream ready: always 1, or 30% random duty.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge axi_clk); #1;
      if (rdy_mode == 1) bus.tx_ready = ($urandom_range(0, 99) < 30);
      else               bus.tx_ready = 1'b1;
    end
  end

  task automatic step();
    @(posedge axi_clk); #1;
  endtask

  task automatic send_pix(input logic [23:0] d, input bit last);
    bit acc;
    acc = 0;
    if (pix_to != 0) return;
    bus.pix_valid = 1'b1; bus.pix_data = d; bus.pix_last = last;
    for (int i = 0; i < 2000 && !acc; i++) begin
      @(negedge axi_clk);
      acc = (bus.pix_ready === 1'b1);
      step();
    end
    if (acc) model_pixel(d, last);
    else pix_to++;
  endtask

  task automatic pulse_frame();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    model_frame();
  endtask

  // Waits (bounded) for the expected number of words, then moves them into obs_q/ref_q.
  task automatic collect(input int budget);
    for (int i = 0; i < budget && (got_q.size() - got_rd) < exp_q.size(); i++) step();
    repeat (4) step();
    obs_q.delete();
    for (int i = got_rd; i < got_q.size(); i++) obs_q.push_back(got_q[i]);
    got_rd = got_q.size();
    ref_q = exp_q;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); else n_pass++;
    n_total++; if (bus.tx_data !== 64'h0) $display("FAIL reset_tx_data: got %h want 0", bus.tx_data); else n_pass++;
    n_total++; if (bus.pix_ready !== 1'b0) $display("FAIL reset_pix_ready: got %b want 0", bus.pix_ready); else n_pass++;
    n_total++; if (bus.synced !== 1'b0) $display("FAIL reset_synced: got %b want 0", bus.synced); else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL post_reset_tx_valid: got %b want 0", bus.tx_valid); else n_pass++;
  endtask

  task automatic test_drop_then_frame();
    for (int i = 0; i < 5; i++) send_pix(24'($urandom), 1'b0);
    bus.pix_valid = 1'b0;
    pulse_frame();
    collect(200);
    n_total++; if (obs_q.size() !== 1) $display("FAIL drop_word_count: got %0d want 1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0) begin
      n_total++; if (obs_q[0] !== 64'hFEFEFEFEFEFE_C000) $display("FAIL first_boundary: got %h want %h", obs_q[0], 64'hFEFEFEFEFEFE_C000); else n_pass++;
    end
    n_total++; if (bus.synced !== 1'b1) $display("FAIL synced_after_bnd: got %b want 1", bus.synced); else n_pass++;
    n_total++; if (pix_to !== 0) $display("FAIL drop_pix_timeout: got %0d want 0", pix_to); else n_pass++;
`ifdef HDMI_PACK_STATS_EN
    n_total++; if (bus.drop_cnt !== 16'd5) $display("FAIL drop_cnt: got %0d want 5", bus.drop_cnt); else n_pass++;
`endif
  endtask

  task automatic test_pair();
    send_pix(24'h111111, 1'b0);
    send_pix(24'h222222, 1'b1);
    bus.pix_valid = 1'b0;
    collect(200);
    n_total++; if (obs_q.size() !== 1) $display("FAIL pair_count: got %0d want 1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0) begin
      n_total++; if (obs_q[0] !== 64'h222222_111111_8000) $display("FAIL pair_word: got %h want %h", obs_q[0], 64'h222222_111111_8000); else n_pass++;
      n_total++; if (obs_q[0] !== ref_q[0]) $display("FAIL pair_model: got %h want %h", obs_q[0], ref_q[0]); else n_pass++;
    end
  endtask

  task automatic test_three();
    logic [23:0] a, b, c;
    a = 24'($urandom); b = 24'($urandom); c = 24'($urandom);
    send_pix(a, 1'b0);
    send_pix(b, 1'b0);
    send_pix(c, 1'b1);
    bus.pix_valid = 1'b0;
    collect(200);
    n_total++; if (obs_q.size() !== 2) $display("FAIL three_count: got %0d want 2", obs_q.size()); else n_pass++;
    if (obs_q.size() > 1) begin
      n_total++; if (obs_q[0] !== {b, a, 16'h8001}) $display("FAIL three_dual: got %h want %h", obs_q[0], {b, a, 16'h8001}); else n_pass++;
      n_total++; if (obs_q[1] !== {24'h0, c, 16'h4001}) $display("FAIL three_single: got %h want %h", obs_q[1], {24'h0, c, 16'h4001}); else n_pass++;
      for (int i = 0; i < 2; i++) begin
        n_total++; if (obs_q[i] !== ref_q[i]) $display("FAIL three_model[%0d]: got %h want %h", i, obs_q[i], ref_q[i]); else n_pass++;
      end
    end
  endtask

  task automatic test_flush();
    logic [23:0] p, q, r;
    p = 24'($urandom); q = 24'($urandom); r = 24'($urandom);
    send_pix(p, 1'b0);
    bus.pix_valid = 1'b0;
    step();
    pulse_frame();
    send_pix(q, 1'b0);
    send_pix(r, 1'b1);
    bus.pix_valid = 1'b0;
    collect(200);
    n_total++; if (obs_q.size() !== 3) $display("FAIL flush_count: got %0d want 3", obs_q.size()); else n_pass++;
    if (obs_q.size() > 2) begin
      n_total++; if (obs_q[0] !== {24'h0, p, 16'h4002}) $display("FAIL flush_word: got %h want %h", obs_q[0], {24'h0, p, 16'h4002}); else n_pass++;
      n_total++; if (obs_q[1] !== {BND, 16'hC001}) $display("FAIL flush_boundary: got %h want %h", obs_q[1], {BND, 16'hC001}); else n_pass++;
      n_total++; if (obs_q[2] !== {r, q, 16'h8000}) $display("FAIL flush_next_line0: got %h want %h", obs_q[2], {r, q, 16'h8000}); else n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_total++; if (obs_q[i] !== ref_q[i]) $display("FAIL flush_model[%0d]: got %h want %h", i, obs_q[i], ref_q[i]); else n_pass++;
      end
    end
`ifdef HDMI_PACK_STATS_EN
    n_total++; if (len_err_cnt !== 1) $display("FAIL frame_len_err_count: got %0d want 1", len_err_cnt); else n_pass++;
`endif
  endtask

  task automatic test_backpressure();
    int duals;
    rdy_mode = 1;
    pulse_frame();
    for (int i = 0; i < 1920; i++) send_pix(24'($urandom), (i == 1919));
    bus.pix_valid = 1'b0;
    collect(20000);
    rdy_mode = 0;
    n_total++; if (obs_q.size() !== 961) $display("FAIL bp_count: got %0d want 961", obs_q.size()); else n_pass++;
    duals = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i][15:14] == 2'b10) duals++;
    n_total++; if (duals !== 960) $display("FAIL bp_dual_count: got %0d want 960", duals); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < ref_q.size(); i++) begin
      n_total++; if (obs_q[i] !== ref_q[i]) $display("FAIL bp_word[%0d]: got %h want %h", i, obs_q[i], ref_q[i]); else n_pass++;
    end
    n_total++; if (stall_viol !== 0) $display("FAIL bp_stall_stable: got %0d violations want 0", stall_viol); else n_pass++;
    n_total++; if (pix_to !== 0) $display("FAIL bp_pix_timeout: got %0d want 0", pix_to); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [23:0] h, x, y;
    h = 24'($urandom); x = 24'($urandom); y = 24'($urandom);
    pulse_frame();
    send_pix(h, 1'b0);
    bus.pix_valid = 1'b0;
    collect(200);
    n_total++; if (obs_q.size() !== 1 || obs_q[0] !== ref_q[0]) $display("FAIL mid_pre_boundary: got %h want %h", obs_q.size() > 0 ? obs_q[0] : 64'hx, ref_q[0]); else n_pass++;
    n_total++; if (bus.synced !== 1'b1) $display("FAIL mid_synced_before: got %b want 1", bus.synced); else n_pass++;
    @(posedge axi_clk); #3;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL mid_reset_tx_valid: got %b want 0", bus.tx_valid); else n_pass++;
    n_total++; if (bus.synced !== 1'b0) $display("FAIL mid_reset_synced: got %b want 0", bus.synced); else n_pass++;
    n_total++; if (bus.pix_ready !== 1'b0) $display("FAIL mid_reset_pix_ready: got %b want 0", bus.pix_ready); else n_pass++;
    model_reset();
    step();
    rst_n = 1'b1;
    step();
    pulse_frame();
    send_pix(x, 1'b0);
    send_pix(y, 1'b1);
    bus.pix_valid = 1'b0;
    collect(200);
    n_total++; if (obs_q.size() !== 2) $display("FAIL mid_post_count: got %0d want 2", obs_q.size()); else n_pass++;
    if (obs_q.size() > 1) begin
      n_total++; if (obs_q[0] !== {BND, 16'hC000}) $display("FAIL mid_post_boundary: got %h want %h", obs_q[0], {BND, 16'hC000}); else n_pass++;
      n_total++; if (obs_q[1] !== {y, x, 16'h8000}) $display("FAIL mid_post_dual: got %h want %h", obs_q[1], {y, x, 16'h8000}); else n_pass++;
      for (int i = 0; i < 2; i++) begin
        n_total++; if (obs_q[i] !== ref_q[i]) $display("FAIL mid_model[%0d]: got %h want %h", i, obs_q[i], ref_q[i]); else n_pass++;
      end
    end
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = '0;
    bus.pix_last    = 1'b0;
    model_reset();
    test_reset();
    test_drop_then_frame();
    test_pair();
    test_three();
    test_flush();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
